// File: rtl/mmio_pkg.sv
// mmio_pkg: shared constants for the MMIO responder.
//   MMIO_BASE   - upper 24 address bits that select the register window
//   OFF_*       - byte offsets of the registers inside that window
//   SEG7_GLYPH  - active-low seven-segment glyphs {g,f,e,d,c,b,a} for hex 0..F
package mmio_pkg;

  localparam logic [23:0] MMIO_BASE  = 24'hFFFFFF;

  localparam logic [7:0]  OFF_DISP   = 8'h00;
  localparam logic [7:0]  OFF_SWREG  = 8'h04;
  localparam logic [7:0]  OFF_CYCLE  = 8'h08;
  localparam logic [7:0]  OFF_WCOUNT = 8'h0C;

  localparam logic [6:0] SEG7_GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,  // 0 1 2 3
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,  // 4 5 6 7
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,  // 8 9 A b
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110   // C d E F
  };

endpackage

// File: rtl/seg7_hex.sv
// seg7_hex: one hex digit to an active-low seven-segment pattern.
//   hex_i - 4-bit digit value
//   seg_o - 7-bit segment drive {g,f,e,d,c,b,a}, 0 = segment lit
module seg7_hex
  import mmio_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_GLYPH[hex_i];

endmodule

// File: rtl/mmio_responder.sv
// mmio_responder: data RAM plus a small MMIO register window for a
// single-cycle processor.
//   clk        - clock, all state changes on the rising edge
//   reset      - asynchronous, active low
//   memwrite   - store strobe
//   dataadr    - byte address; 0xFFFFFFxx selects MMIO, anything else RAM
//   writedata  - store data
//   readdata   - load data, combinational from dataadr
//   SW         - asynchronous board switches (5)
//   gled..gled4- active-low seven-segment digits 0..3 showing DISP
// Registers: DISP (0x00, 16b R/W), SWREG (0x04, RO), CYCLE (0x08, write
// clears), WCOUNT (0x0C, saturating RAM-store count, write clears).
// Build option: define MMIO_SW_DEBOUNCE_EN to debounce SWREG over
// DEBOUNCE_CYCLES clocks; otherwise SWREG is the synchronizer output.
module mmio_responder
  import mmio_pkg::*;
#(
  parameter int MEM_WORDS       = 64,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memwrite,
  input  logic [31:0] dataadr,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic [4:0]  SW,
  output logic [6:0]  gled,
  output logic [6:0]  gled2,
  output logic [6:0]  gled3,
  output logic [6:0]  gled4
);

  localparam int AW = $clog2(MEM_WORDS);

  // ---------------- address decode ----------------
  logic          is_mmio;
  logic [AW-1:0] widx;
  logic [7:0]    off;
  logic          wr_ram, wr_disp, wr_cycle, wr_wcount;
  logic          unused_addr_lsb;

  assign is_mmio   = (dataadr[31:8] == MMIO_BASE);
  assign widx      = dataadr[AW+1:2];
  assign off       = {dataadr[7:2], 2'b00};
  assign unused_addr_lsb = ^dataadr[1:0];

  assign wr_ram    = memwrite & ~is_mmio;
  assign wr_disp   = memwrite & is_mmio & (off == OFF_DISP);
  assign wr_cycle  = memwrite & is_mmio & (off == OFF_CYCLE);
  assign wr_wcount = memwrite & is_mmio & (off == OFF_WCOUNT);

  // ---------------- data RAM (not reset) ----------------
  logic [31:0] mem_q [MEM_WORDS];

  // Gating on reset drops a store that coincides with reset assertion.
  always_ff @(posedge clk) begin
    if (reset && wr_ram) mem_q[widx] <= writedata;
  end

  // ---------------- MMIO registers ----------------
  logic [15:0] disp_q,   disp_d;
  logic [31:0] cycle_q,  cycle_d;
  logic [15:0] wcount_q, wcount_d;

  always_comb begin
    disp_d   = wr_disp ? writedata[15:0] : disp_q;
    cycle_d  = wr_cycle ? 32'd0 : cycle_q + 32'd1;
    wcount_d = wcount_q;
    if (wr_wcount)
      wcount_d = 16'd0;
    else if (wr_ram && wcount_q != 16'hFFFF)
      wcount_d = wcount_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q   <= '0;
      cycle_q  <= '0;
      wcount_q <= '0;
    end else begin
      disp_q   <= disp_d;
      cycle_q  <= cycle_d;
      wcount_q <= wcount_d;
    end
  end

  // ---------------- switch synchronizer / SWREG ----------------
  logic [4:0] sw_meta_q, sw_sync_q;
  logic [4:0] swreg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      sw_meta_q <= SW;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef MMIO_SW_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [4:0]    swreg_q, swreg_d;
  logic [4:0]    cand_q,  cand_d;
  logic [CW-1:0] cnt_q,   cnt_d;
  logic [CW-1:0] run;

  // run = number of consecutive clocks (including this one) that the
  // synchronized value has held the same, non-SWREG value.
  always_comb begin
    run     = (sw_sync_q == cand_q && sw_sync_q != swreg_q) ? cnt_q + CW'(1) : CW'(1);
    swreg_d = swreg_q;
    cand_d  = sw_sync_q;
    cnt_d   = '0;
    if (sw_sync_q != swreg_q) begin
      if (run >= CW'(DEBOUNCE_CYCLES)) swreg_d = sw_sync_q;
      else                             cnt_d   = run;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      swreg_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      swreg_q <= swreg_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  assign swreg = swreg_q;
`else
  // Second synchronizer stage is SWREG: two-clock latency from the pins.
  assign swreg = sw_sync_q;
`endif

  // ---------------- load path ----------------
  always_comb begin
    readdata = mem_q[widx];
    if (is_mmio) begin
      case (off)
        OFF_DISP:   readdata = {16'd0, disp_q};
        OFF_SWREG:  readdata = {27'd0, swreg};
        OFF_CYCLE:  readdata = cycle_q;
        OFF_WCOUNT: readdata = {16'd0, wcount_q};
        default:    readdata = 32'd0;
      endcase
    end
  end

  // ---------------- seven-segment digits ----------------
  logic [3:0][6:0] seg;

  for (genvar g = 0; g < 4; g++) begin : g_seg
    seg7_hex u_seg7 (
      .hex_i (disp_q[4*g +: 4]),
      .seg_o (seg[g])
    );
  end

  assign gled  = seg[0];
  assign gled2 = seg[1];
  assign gled3 = seg[2];
  assign gled4 = seg[3];

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: scoreboard bench for mmio_responder. Stimulus tasks
// push the expected value from a behavioural model; a negedge monitor pops
// and compares whenever chk_vld is raised.
module tb_mmio_responder;

  localparam int MW = 64;
  localparam int DB = 4;
`ifdef MMIO_SW_DEBOUNCE_EN
  localparam int SW_LAT = 2 + DB;
`else
  localparam int SW_LAT = 2;
`endif

  localparam logic [31:0] A_DISP   = 32'hFFFFFF00;
  localparam logic [31:0] A_SWREG  = 32'hFFFFFF04;
  localparam logic [31:0] A_CYCLE  = 32'hFFFFFF08;
  localparam logic [31:0] A_WCOUNT = 32'hFFFFFF0C;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        memwrite = 1'b0;
  logic [31:0] dataadr = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [4:0]  SW = '0;
  logic [6:0]  gled, gled2, gled3, gled4;

  always #5 clk = ~clk;

  mmio_responder #(.MEM_WORDS(MW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .readdata(readdata), .SW(SW),
    .gled(gled), .gled2(gled2), .gled3(gled3), .gled4(gled4)
  );

  // ---------------- reference model ----------------
  logic [6:0]  GLYPH [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [31:0] m_ram [MW];
  bit          m_ok  [MW];
  logic [15:0] m_disp = '0;
  int          m_wc = 0;
  logic [4:0]  m_sw = '0;
  int          edge_cnt = 0;   // rising edges seen with reset released
  int          clr_edge = 0;   // edge_cnt value when CYCLE was last zeroed

  always @(posedge clk) if (reset) edge_cnt <= edge_cnt + 1;

  function automatic int ridx(input logic [31:0] a);
    return int'((a / 4) % MW);
  endfunction

  function automatic logic is_io(input logic [31:0] a);
    return a[31:8] == 24'hFFFFFF;
  endfunction

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (!is_io(a)) return m_ram[ridx(a)];
    case (a[7:0] & 8'hFC)
      8'h00:   return {16'd0, m_disp};
      8'h04:   return {27'd0, m_sw};
      8'h08:   return 32'(edge_cnt - clr_edge);
      8'h0C:   return 32'(m_wc);
      default: return 32'd0;
    endcase
  endfunction

  // Called just after the edge that performed the store.
  task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
    if (is_io(a)) begin
      case (a[7:0] & 8'hFC)
        8'h00:   m_disp = d[15:0];
        8'h08:   clr_edge = edge_cnt;
        8'h0C:   m_wc = 0;
        default: ;
      endcase
    end else begin
      m_ram[ridx(a)] = d;
      m_ok[ridx(a)]  = 1'b1;
      m_wc = (m_wc < 65535) ? m_wc + 1 : 65535;
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    string       tag;
    int          kind;   // 0: readdata, 1: {gled4,gled3,gled2,gled}
    logic [31:0] exp;
  } exp_t;

  exp_t        sb[$];
  logic        chk_vld = 1'b0;
  int          n_cmp = 0;
  int          n_err = 0;
  exp_t        mon_e;
  logic [31:0] mon_act;

  always @(negedge clk) begin
    if (chk_vld) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_empty: output presented with no expectation queued");
      end else begin
        mon_e   = sb.pop_front();
        mon_act = (mon_e.kind == 0) ? readdata : {4'd0, gled4, gled3, gled2, gled};
        if (mon_act !== mon_e.exp) begin
          n_err++;
          $display("FAIL %s: got %h expected %h (t=%0t)", mon_e.tag, mon_act, mon_e.exp, $time);
        end
      end
    end
  end

  // ---------------- stimulus tasks (entered at posedge+1) ----------------
  task automatic push(input string tag, input int kind, input logic [31:0] exp);
    exp_t e;
    e.tag = tag; e.kind = kind; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    dataadr = a; writedata = d; memwrite = 1'b1;
    @(posedge clk); #1;
    memwrite = 1'b0;
    model_wr(a, d);
  endtask

  task automatic rd(input logic [31:0] a, input string tag);
    dataadr = a; memwrite = 1'b0;
    push(tag, 0, model_rd(a));
    chk_vld = 1'b1;
    @(posedge clk); #1;
    chk_vld = 1'b0;
  endtask

  function automatic logic [31:0] led_exp();
    return {4'd0, GLYPH[m_disp[15:12]], GLYPH[m_disp[11:8]],
            GLYPH[m_disp[7:4]], GLYPH[m_disp[3:0]]};
  endfunction

  task automatic chk_led(input string tag);
    push(tag, 1, led_exp());
    chk_vld = 1'b1;
    @(posedge clk); #1;
    chk_vld = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [31:0] a;
    int          op;

    for (int i = 0; i < MW; i++) m_ok[i] = 1'b0;

    // Reset state
    @(posedge clk); #1;
    rd(A_DISP,   "rst_disp");
    rd(A_CYCLE,  "rst_cycle");
    rd(A_WCOUNT, "rst_wcount");
    rd(A_SWREG,  "rst_swreg");
    chk_led("rst_leds");
    reset = 1'b1;

    // Store then load, WCOUNT
    wr(32'h54, 32'd7);
    rd(32'h54,   "ram_0x54");
    rd(A_WCOUNT, "wcount_after_one");

    // DISP drives the digits, RAM untouched
    wr(32'h0, 32'h600D);
    wr(A_DISP, 32'h1234);
    chk_led("leds_1234");
    rd(32'h0,  "ram0_after_disp");
    rd(A_DISP, "disp_1234");

    // Address wrap
    wr(32'h100, 32'hAA);
    rd(32'h0, "ram_wrap");

    // CYCLE clear then counting
    wr(A_CYCLE, 32'hDEAD_BEEF);
    for (int k = 0; k < 6; k++) rd(A_CYCLE, "cycle_after_clear");

    // Unmapped / read-only / low address bits
    wr(32'hFFFFFF10, 32'hFFFF_FFFF);
    rd(32'hFFFFFF10, "unmapped_rd");
    wr(A_SWREG, 32'h1F);
    rd(A_SWREG, "swreg_write_ignored");
    rd(32'hFFFFFFFC, "unmapped_top");
    wr(32'hFFFFFF03, 32'h0000_CAFE);
    chk_led("leds_cafe");
    rd(32'hFFFFFF02, "disp_lsb_ignored");

    // Switch latency
    SW = 5'b10101;
    for (int k = 0; k <= SW_LAT; k++) begin
      m_sw = (k >= SW_LAT) ? 5'h15 : 5'h00;
      rd(A_SWREG, "swreg_latency");
    end
`ifdef MMIO_SW_DEBOUNCE_EN
    SW = 5'b01010;
    @(posedge clk); #1;
    SW = 5'b10101;
    for (int k = 0; k < SW_LAT + 3; k++) rd(A_SWREG, "swreg_glitch");
`endif
    SW = 5'b00000;
    repeat (SW_LAT + 2) @(posedge clk);
    #1;
    m_sw = 5'h00;
    rd(A_SWREG, "swreg_back_zero");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      op = int'($urandom_range(0, 5));
      a  = $urandom_range(0, 32'h00FF_FFFF);
      case (op)
        0, 1: wr(a, $urandom);
        2:    if (m_ok[ridx(a)]) rd(a, "rand_ram");
        3:    begin
                wr(A_DISP + 32'($urandom_range(0, 3)), $urandom);
                chk_led("rand_leds");
              end
        4:    rd(A_DISP + 32'($urandom_range(0, 255)), "rand_mmio_rd");
        default: wr(A_DISP + 32'($urandom_range(0, 255)), $urandom);
      endcase
    end

    // WCOUNT saturation and clear
    wr(A_WCOUNT, 32'd0);
    memwrite = 1'b1;
    for (int i = 0; i < 32'h10002; i++) begin
      dataadr = 32'(i) * 4; writedata = 32'(i) ^ 32'h5A5A_0000;
      @(posedge clk); #1;
      model_wr(32'(i) * 4, 32'(i) ^ 32'h5A5A_0000);
    end
    memwrite = 1'b0;
    rd(A_WCOUNT, "wcount_saturated");
    rd(32'h8,    "ram_after_burst");
    wr(A_WCOUNT, 32'd0);
    rd(A_WCOUNT, "wcount_cleared");

    // Reset in the middle of a store
    wr(A_DISP, 32'hBEEF);
    chk_led("leds_beef");
    wr(32'h20, 32'h1111);
    dataadr = 32'h20; writedata = 32'h5555; memwrite = 1'b1;
    #1;
    reset = 1'b0;
    m_disp = '0; m_wc = 0; m_sw = '0; clr_edge = edge_cnt;
    push("leds_in_reset", 1, led_exp());
    chk_vld = 1'b1;
    @(posedge clk); #1;
    chk_vld = 1'b0; memwrite = 1'b0;
    rd(A_DISP,   "disp_in_reset");
    rd(A_CYCLE,  "cycle_in_reset");
    rd(A_WCOUNT, "wcount_in_reset");
    reset = 1'b1;
    rd(32'h20,   "store_dropped_by_reset");
    rd(A_CYCLE,  "cycle_after_reset");
    rd(A_WCOUNT, "wcount_after_reset");
    wr(32'h24, 32'h77);
    rd(32'h24,   "ram_after_reset");
    rd(A_WCOUNT, "wcount_counts_after_reset");

    @(negedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_leftover: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
